// File: rtl/rgb_sequencer.sv
// ============================================================================
//  Module   : rgb_sequencer
//  Purpose  : Colour sequencer ahead of the RGB PWM mixer. Passes manual levels
//             through, or ramps through a programmable table of RGB targets.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_sequencer #(
  parameter int WIDTH    = 8,
  parameter int STEPS    = 4,
  parameter int DIV_BITS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         man_level0,
  input  logic [WIDTH-1:0]         man_level1,
  input  logic [WIDTH-1:0]         man_level2,
  input  logic                     cfg_we,
  input  logic [4:0]               cfg_addr,
  input  logic [31:0]              cfg_data,
  input  logic                     start,
  input  logic                     stop,
  output logic [WIDTH-1:0]         level0,
  output logic [WIDTH-1:0]         level1,
  output logic [WIDTH-1:0]         level2,
  output logic                     busy,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     done
);

  localparam int                 c_IDX_W    = $clog2(STEPS);
  localparam int                 c_HOLD_LSB = 3 * WIDTH;
  localparam logic [c_IDX_W-1:0] c_LAST     = c_IDX_W'(STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RAMP  = 3'd2,
    S_HOLD  = 3'd3,
    S_FINAL = 3'd4
  } state_t;

  // Configuration registers
  logic                loop_q;
  logic [DIV_BITS-1:0] div_q;
  logic [WIDTH-1:0]    tab_q      [STEPS][3];
  logic [7:0]          hold_tab_q [STEPS];

  // Sequencer state
  state_t              state_q;
  logic                busy_q;
  logic                done_q;
  logic [c_IDX_W-1:0]  sidx_q;
  logic [DIV_BITS-1:0] cnt_q;
  logic [7:0]          hold_cnt_q;
  logic [WIDTH-1:0]    lvl_q [3];
  logic [WIDTH-1:0]    tgt_q [3];

  logic [WIDTH-1:0]    w_man [3];
  logic [DIV_BITS-1:0] w_div_last;
  logic                w_tick;
  logic                w_at_tgt;

  assign w_man[0] = man_level0;
  assign w_man[1] = man_level1;
  assign w_man[2] = man_level2;

  // A divider of zero behaves like one: tick every cycle.
  assign w_div_last = (div_q == '0) ? '0 : div_q - DIV_BITS'(1);
  assign w_tick     = (cnt_q == w_div_last);

  always_comb begin
    w_at_tgt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (lvl_q[k] != tgt_q[k]) w_at_tgt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      loop_q <= 1'b0;
      div_q  <= '0;
      for (int i = 0; i < STEPS; i++) begin
        hold_tab_q[i] <= '0;
        for (int k = 0; k < 3; k++) tab_q[i][k] <= '0;
      end
    end else if (cfg_we) begin
      if (cfg_addr == 5'd0) loop_q <= cfg_data[0];
      if (cfg_addr == 5'd1) div_q  <= cfg_data[DIV_BITS-1:0];
      for (int i = 0; i < STEPS; i++) begin
        if (cfg_addr == 5'(i + 2)) begin
          hold_tab_q[i] <= cfg_data[c_HOLD_LSB +: 8];
          for (int k = 0; k < 3; k++) tab_q[i][k] <= cfg_data[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sidx_q     <= '0;
      cnt_q      <= '0;
      hold_cnt_q <= '0;
      for (int k = 0; k < 3; k++) begin
        lvl_q[k] <= '0;
        tgt_q[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      // Prescaler only runs in RAMP/HOLD, so every LOAD restarts it from zero.
      if (state_q == S_RAMP || state_q == S_HOLD)
        cnt_q <= w_tick ? '0 : cnt_q + DIV_BITS'(1);
      else
        cnt_q <= '0;

      case (state_q)
        S_IDLE: begin
          for (int k = 0; k < 3; k++) lvl_q[k] <= w_man[k];
          if (start && !stop) begin
            state_q <= S_LOAD;
            sidx_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            for (int k = 0; k < 3; k++) tgt_q[k] <= tab_q[sidx_q][k];
            hold_cnt_q <= hold_tab_q[sidx_q];
            state_q    <= S_RAMP;
          end
        end
        S_RAMP: begin
          if (stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (w_at_tgt) begin
            state_q <= S_HOLD;
          end else if (w_tick) begin
            for (int k = 0; k < 3; k++) begin
              if (lvl_q[k] < tgt_q[k])      lvl_q[k] <= lvl_q[k] + WIDTH'(1);
              else if (lvl_q[k] > tgt_q[k]) lvl_q[k] <= lvl_q[k] - WIDTH'(1);
            end
          end
        end
        S_HOLD: begin
          if (stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (w_tick) begin
            if (hold_cnt_q != 8'd0) begin
              hold_cnt_q <= hold_cnt_q - 8'd1;
            end else if (sidx_q != c_LAST) begin
              sidx_q  <= sidx_q + c_IDX_W'(1);
              state_q <= S_LOAD;
            end else if (loop_q) begin
              sidx_q  <= '0;
              state_q <= S_LOAD;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_FINAL;
            end
          end
        end
        S_FINAL: begin
          if (stop) begin
            state_q <= S_IDLE;
          end else if (start) begin
            state_q <= S_LOAD;
            sidx_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign level0   = lvl_q[0];
  assign level1   = lvl_q[1];
  assign level2   = lvl_q[2];
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = sidx_q;

endmodule

`default_nettype wire
